// File: rtl/lfsr_misr_checker.sv
// LFSR stimulus generator plus MISR response compactor, with a signature compare at the end of the run.
// done rises TOTAL-1 edges after start. Defining LMC_HOLD_EN adds a hold input that stalls RUN one edge per held cycle.
module lfsr_misr_checker #(
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] TAPS    = 64'h8000_0000_0000_0005,
  parameter logic [WIDTH-1:0] SEED    = 64'h5aef0c8d_d70a4497,
  parameter int               WARM    = 10,
  parameter int               TOTAL   = 100,
  parameter logic [WIDTH-1:0] EXP_CRC = 64'hc77bb9b3_784ea091,
  parameter logic [WIDTH-1:0] EXP_SUM = 64'h0,
  localparam int              CW      = $clog2(TOTAL) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef LMC_HOLD_EN
  input  logic             hold,
`endif
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] stim,
  output logic [WIDTH-1:0] sig,
  output logic [CW-1:0]    cyc,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CYC_LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] CYC_WARM = CW'(WARM);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             stall;

  function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

`ifdef LMC_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    sig_d   = sig_q;
    cyc_d   = cyc_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          stim_d  = SEED;
          sig_d   = '0;
          cyc_d   = CW'(1);
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (cyc_q == CYC_LAST) begin
            // Check edge: stim/sig/cyc stay put so the compared values remain visible.
            pass_d  = (stim_q == EXP_CRC) && (sig_q == EXP_SUM);
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            stim_d = lfsr_shift(stim_q);
            cyc_d  = cyc_q + CW'(1);
            sig_d  = (cyc_q < CYC_WARM) ? '0 : (result ^ lfsr_shift(sig_q));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      sig_q   <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      sig_q   <= sig_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign stim = stim_q;
  assign sig  = sig_q;
  assign cyc  = cyc_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_lfsr_misr_checker.sv
// Randomized self-checking bench for lfsr_misr_checker against a value-level LFSR/MISR reference model.
module tb_lfsr_misr_checker;

  localparam int          WIDTH   = 64;
  localparam logic [63:0] TAPS    = 64'h8000_0000_0000_0005;
  localparam logic [63:0] SEED    = 64'h5aef0c8d_d70a4497;
  localparam int          WARM    = 10;
  localparam int          TOTAL   = 100;
  localparam logic [63:0] EXP_CRC = 64'hc77bb9b3_784ea091;
  localparam logic [63:0] EXP_SUM = 64'h0;
  localparam int          CW      = $clog2(TOTAL) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  stim;
  logic [WIDTH-1:0]  sig;
  logic [CW-1:0]     cyc;
  logic              busy;
  logic              done;
  logic              pass;
`ifdef LMC_HOLD_EN
  logic              hold;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] rnd [TOTAL];

  always #5 clk = ~clk;

  lfsr_misr_checker dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
`ifdef LMC_HOLD_EN
    .hold   (hold),
`endif
    .result (result),
    .stim   (stim),
    .sig    (sig),
    .cyc    (cyc),
    .busy   (busy),
    .done   (done),
    .pass   (pass)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] shl(input logic [63:0] x);
    return {x[62:0], ^(x & TAPS)};
  endfunction

  // One full run from a start pulse; the model advances per edge from the rules, lat is the required start->done edge count.
  task automatic run(input string tag, input int mode, input int flip_at, input int restart_at,
                     input int hold_at, input int hold_len, input int lat);
    logic [63:0] m_stim, m_sig, r;
    int          m_cyc, held;
    bit          early, hold_now, mid_seen;
    @(negedge clk);
    start  = 1'b1;
    result = {$urandom(), $urandom()};
    @(negedge clk);
    start  = 1'b0;
    m_stim = SEED;
    m_sig  = '0;
    m_cyc  = 1;
    held   = 0;
    early  = 1'b0;
    mid_seen = 1'b0;
    check({tag, "/start_cyc"}, 64'(cyc), 64'd1);
    check({tag, "/start_done"}, 64'(done), 64'd0);
    check({tag, "/start_pass"}, 64'(pass), 64'd0);
    check({tag, "/start_busy"}, 64'(busy), 64'd1);
    for (int e = 0; e < lat; e++) begin
      case (mode)
        0:       r = 64'd0;
        1:       r = 64'd1;
        default: r = rnd[m_cyc];
      endcase
      if (m_cyc == flip_at) r[7] = ~r[7];
      result   = r;
      start    = (m_cyc == restart_at);
      hold_now = (hold_len > 0) && (m_cyc == hold_at) && (held < hold_len);
`ifdef LMC_HOLD_EN
      hold = hold_now;
`endif
      if (m_cyc == 50 && !mid_seen) begin
        mid_seen = 1'b1;
        check({tag, "/mid_stim"}, stim, m_stim);
        check({tag, "/mid_sig"}, sig, m_sig);
        check({tag, "/mid_cyc"}, 64'(cyc), 64'(m_cyc));
      end
      @(negedge clk);
      if (hold_now) begin
        held++;
      end else if (m_cyc < TOTAL - 1) begin
        m_sig  = (m_cyc < WARM) ? 64'd0 : (r ^ shl(m_sig));
        m_stim = shl(m_stim);
        m_cyc++;
      end
      if (e < lat - 1 && done) early = 1'b1;
    end
    start = 1'b0;
`ifdef LMC_HOLD_EN
    hold = 1'b0;
`endif
    check({tag, "/early_done"}, 64'(early), 64'd0);
    check({tag, "/done"}, 64'(done), 64'd1);
    check({tag, "/busy_end"}, 64'(busy), 64'd0);
    check({tag, "/stim"}, stim, m_stim);
    check({tag, "/sig"}, sig, m_sig);
    check({tag, "/cyc"}, 64'(cyc), 64'(TOTAL - 1));
    check({tag, "/pass"}, 64'(pass), 64'((m_stim == EXP_CRC) && (m_sig == EXP_SUM)));
    result = {$urandom(), $urandom()};
    @(negedge clk);
    check({tag, "/hold_done"}, 64'(done), 64'd1);
    check({tag, "/hold_stim"}, stim, m_stim);
    check({tag, "/hold_sig"}, sig, m_sig);
  endtask

  initial begin
    logic [63:0] s;
    rst    = 1'b1;
    start  = 1'b0;
    result = '0;
`ifdef LMC_HOLD_EN
    hold   = 1'b0;
`endif

    // Random responses, with the last compacted word chosen so the final signature lands on EXP_SUM.
    for (int k = 0; k < TOTAL; k++) rnd[k] = {$urandom(), $urandom()};
    s = '0;
    for (int k = 1; k <= TOTAL - 3; k++) s = (k < WARM) ? 64'd0 : (rnd[k] ^ shl(s));
    rnd[TOTAL-2] = shl(s) ^ EXP_SUM;

    #12;
    check("rst_stim", stim, 64'd0);
    check("rst_sig", sig, 64'd0);
    check("rst_cyc", 64'(cyc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("zero",     0, -1, -1, -1, 0, TOTAL - 1);
    run("ones",     1, -1, -1, -1, 0, TOTAL - 1);
    run("rand",     2, -1, -1, -1, 0, TOTAL - 1);
    run("flip50",   2, 50, -1, -1, 0, TOTAL - 1);
    run("flip5",    2,  5, -1, -1, 0, TOTAL - 1);
    run("restart",  0, -1, 20, -1, 0, TOTAL - 1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    check("pre_rst_cyc", 64'(cyc), 64'd40);
    #1 rst = 1'b1;
    #1;
    check("arst_stim", stim, 64'd0);
    check("arst_sig", sig, 64'd0);
    check("arst_cyc", 64'(cyc), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_pass", 64'(pass), 64'd0);
    start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", 64'(busy), 64'd0);
    check("rst_start_cyc", 64'(cyc), 64'd0);
    start = 1'b0;
    rst   = 1'b0;
    run("after_rst", 0, -1, -1, -1, 0, TOTAL - 1);

`ifdef LMC_HOLD_EN
    run("hold", 0, -1, -1, 30, 5, TOTAL - 1 + 5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
